// File: rtl/bcd_count_2digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_count_2digit
// Purpose  : Two-digit BCD up/down counter (00-99) with prescaler, clamped
//            parallel load and a one-cycle terminal-count pulse for cascading.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_count_2digit #(
    parameter int TICK_DIV = 50000000,
    parameter int TICK_W   = 26
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tc
);

    localparam logic [TICK_W-1:0] c_tickMax = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] c_tickOne = TICK_W'(1);

    logic [TICK_W-1:0] r_tickCnt;
    logic              w_step;
    logic [3:0]        w_nextOnes;
    logic [3:0]        w_nextTens;
    logic              w_wrap;

    function automatic logic [3:0] clampDigit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign w_step = en && (r_tickCnt == c_tickMax);

    // Next digit pair for a step in the currently sampled direction.
    always_comb begin
        w_nextOnes = ones;
        w_nextTens = tens;
        w_wrap     = 1'b0;
        if (up) begin
            if (ones >= 4'd9) begin
                w_nextOnes = 4'd0;
                if (tens >= 4'd9) begin
                    w_nextTens = 4'd0;
                    w_wrap     = 1'b1;
                end else begin
                    w_nextTens = tens + 4'd1;
                end
            end else begin
                w_nextOnes = ones + 4'd1;
            end
        end else begin
            if (ones == 4'd0) begin
                w_nextOnes = 4'd9;
                if (tens == 4'd0) begin
                    w_nextTens = 4'd9;
                    w_wrap     = 1'b1;
                end else begin
                    w_nextTens = tens - 4'd1;
                end
            end else begin
                w_nextOnes = ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tickCnt <= '0;
            ones      <= 4'd0;
            tens      <= 4'd0;
            tc        <= 1'b0;
        end else if (load) begin
            r_tickCnt <= '0;
            ones      <= clampDigit(load_val[3:0]);
            tens      <= clampDigit(load_val[7:4]);
            tc        <= 1'b0;
        end else if (w_step) begin
            r_tickCnt <= '0;
            ones      <= w_nextOnes;
            tens      <= w_nextTens;
            tc        <= w_wrap;
        end else begin
            // Prescaler phase is held while paused so the remaining time resumes.
            if (en) begin
                r_tickCnt <= r_tickCnt + c_tickOne;
            end
            tc <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_2digit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_count_2digit
// Purpose  : Self-checking bench for bcd_count_2digit (TICK_DIV=4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_count_2digit;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [3:0] ones4, tens4, ones1, tens1;
    logic       tc4, tc1;

    int nCmp = 0;
    int nFail = 0;
    bit checkOn = 1'b0;
    int tcSeen[2] = '{0, 0};

    // Model state per instance: decimal value, prescaler phase, tc.
    int mVal[2]   = '{0, 0};
    int mPhase[2] = '{0, 0};
    bit mTc[2]    = '{0, 0};
    int mDiv[2]   = '{4, 1};

    always #5 clk = ~clk;

    bcd_count_2digit #(.TICK_DIV(4), .TICK_W(3)) dut4 (
        .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
        .load_val(load_val), .ones(ones4), .tens(tens4), .tc(tc4)
    );

    bcd_count_2digit #(.TICK_DIV(1), .TICK_W(2)) dut1 (
        .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
        .load_val(load_val), .ones(ones1), .tens(tens1), .tc(tc1)
    );

    function automatic int clampNib(input int n);
        return (n > 9) ? 9 : n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int v, p;
            bit t;
            v = mVal[k];
            p = mPhase[k];
            t = 1'b0;
            if (!resetn) begin
                v = 0;
                p = 0;
            end else if (load) begin
                v = clampNib(int'(load_val[7:4])) * 10 + clampNib(int'(load_val[3:0]));
                p = 0;
            end else if (en) begin
                p = p + 1;
                if (p == mDiv[k]) begin
                    p = 0;
                    if (up) begin
                        t = (v == 99);
                        v = (v + 1) % 100;
                    end else begin
                        t = (v == 0);
                        v = (v + 99) % 100;
                    end
                end
            end
            mVal[k]   <= v;
            mPhase[k] <= p;
            mTc[k]    <= t;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            chk("m4.value", int'(tens4) * 10 + int'(ones4), mVal[0]);
            chk("m4.tc", int'(tc4), int'(mTc[0]));
            chk("m1.value", int'(tens1) * 10 + int'(ones1), mVal[1]);
            chk("m1.tc", int'(tc1), int'(mTc[1]));
            if (tc4) tcSeen[0]++;
            if (tc1) tcSeen[1]++;
        end
    end

    // Advance n rising edges, landing just after a falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic lit4(input string name, input int tensE, input int onesE, input int tcE);
        chk({name, ".tens"}, int'(tens4), tensE);
        chk({name, ".ones"}, int'(ones4), onesE);
        chk({name, ".tc"}, int'(tc4), tcE);
    endtask

    initial begin
        int snap;
        #1;
        // Reset
        cycles(1);
        checkOn = 1'b1;
        cycles(1);
        lit4("reset", 0, 0, 0);
        chk("reset.dut1", int'(tens1) * 10 + int'(ones1), 0);

        // Count up from reset for 40 cycles
        resetn = 1'b1; en = 1'b1; up = 1'b1;
        cycles(39);
        lit4("count39", 0, 9, 0);
        cycles(1);
        lit4("count40", 1, 0, 0);
        chk("count.tcSeen", tcSeen[0], 0);
        chk("count.dut1", int'(tens1) * 10 + int'(ones1), 40);

        // Up wrap from 98
        load = 1'b1; load_val = 8'h98;
        cycles(1);
        load = 1'b0;
        lit4("load98", 9, 8, 0);
        snap = tcSeen[0];
        cycles(4);
        lit4("wrap99", 9, 9, 0);
        cycles(4);
        lit4("wrap00", 0, 0, 1);
        cycles(4);
        lit4("wrap01", 0, 1, 0);
        chk("wrap.tcCount", tcSeen[0] - snap, 1);

        // Down from 10 through borrow to 99
        load = 1'b1; load_val = 8'h10; up = 1'b0;
        cycles(1);
        load = 1'b0;
        snap = tcSeen[0];
        cycles(4);
        lit4("borrow09", 0, 9, 0);
        cycles(40);
        lit4("down99", 9, 9, 1);
        chk("down.tcCount", tcSeen[0] - snap, 1);

        // Clamped load coincident with a step edge
        up = 1'b1;
        cycles(3);
        load = 1'b1; load_val = 8'hA7;
        cycles(1);
        load = 1'b0;
        lit4("clampA7", 9, 7, 0);
        cycles(3);
        lit4("afterLoad3", 9, 7, 0);
        cycles(1);
        lit4("afterLoad4", 9, 8, 0);

        // Pause preserves prescaler phase
        cycles(2);
        en = 1'b0;
        cycles(10);
        lit4("paused", 9, 8, 0);
        en = 1'b1;
        cycles(1);
        lit4("resume1", 9, 8, 0);
        cycles(1);
        lit4("resume2", 9, 9, 0);

        // Reset on a step edge at 99
        cycles(3);
        resetn = 1'b0;
        cycles(1);
        lit4("midReset", 0, 0, 0);
        chk("midReset.tc1", int'(tc1), 0);
        resetn = 1'b1;

        // TICK_DIV=1: step every cycle, wrap on the 100th step
        cycles(99);
        chk("div1.step99", int'(tens1) * 10 + int'(ones1), 99);
        chk("div1.tc99", int'(tc1), 0);
        cycles(1);
        chk("div1.step100", int'(tens1) * 10 + int'(ones1), 0);
        chk("div1.tc100", int'(tc1), 1);
        cycles(1);
        chk("div1.step101", int'(tens1) * 10 + int'(ones1), 1);
        chk("div1.tc101", int'(tc1), 0);

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
